// File: rtl/btn_evt_fifo_wb.sv
// Button event FIFO with Wishbone slave.
// Turns each changed bit of a button report into a timestamped press/release
// event, buffers the events, and exposes them plus status/control registers
// on a single-slot Wishbone interface with a level interrupt.
module btn_evt_fifo_wb #(
   parameter int DEPTH_LOG2 = 4,
   parameter int TICK_DIV   = 30000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] btn_state,
   input  logic [15:0] btn_change,
   input  logic        btn_stb,
   input  logic [1:0]  wb_addr,
   output logic [31:0] wb_rdata,
   input  logic [31:0] wb_wdata,
   input  logic        wb_we,
   input  logic        wb_cyc,
   output logic        wb_ack,
   output logic        irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0]         PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0]         PRE_ONE  = PW'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [PW-1:0]         pre_q;
   logic [15:0]           ts_q;

   logic [15:0]           pend_q, pend_d;
   logic [15:0]           snap_state_q;
   logic [15:0]           snap_ts_q;

   logic [20:0]           mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   cnt_q;

   logic                  ovf_q;
   logic [7:0]            drop_q;
   logic                  en_q, irqen_q;

   logic                  ack_q;
   logic [31:0]           rdata_q;
   logic                  irq_q;

   logic                  scan_busy;
   logic [3:0]            scan_idx;
   logic [20:0]           scan_evt;
   logic                  fifo_empty, fifo_full;
   logic                  wb_acc, rd_acc, wr_acc;
   logic                  pop, push, drop, stat_clr, capture;
   logic [31:0]           rd_val;
   logic                  unused_wdata;

   assign scan_busy  = |pend_q;
   assign scan_evt   = {snap_state_q[scan_idx], scan_idx, snap_ts_q};
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CNT_FULL);

   // A new access is accepted only when no ack is outstanding, so each
   // access occupies two cycles and its side effects land on the ack edge.
   assign wb_acc   = wb_cyc & ~ack_q;
   assign rd_acc   = wb_acc & ~wb_we;
   assign wr_acc   = wb_acc & wb_we;
   assign pop      = rd_acc & (wb_addr == 2'd1) & ~fifo_empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push     = scan_busy & (~fifo_full | pop);
   assign drop     = scan_busy & fifo_full & ~pop;
   assign stat_clr = wr_acc & (wb_addr == 2'd0) & wb_wdata[8];
   assign capture  = btn_stb & en_q;

   assign unused_wdata = ^{wb_wdata[31:9], wb_wdata[7:2]};

   assign wb_ack   = ack_q;
   assign wb_rdata = rdata_q;
   assign irq      = irq_q;

   // Lowest pending bit is served first.
   always_comb begin
      scan_idx = '0;
      for (int b = 15; b >= 0; b--) begin
         if (pend_q[b]) scan_idx = 4'(b);
      end
   end

   // Scan clear first, then merge a new report so a re-reported bit survives.
   always_comb begin
      pend_d = pend_q;
      if (scan_busy) pend_d[scan_idx] = 1'b0;
      if (capture)   pend_d = pend_d | btn_change;
   end

   // Register read mux, evaluated in the accepting cycle.
   always_comb begin
      rd_val = '0;
      case (wb_addr)
         2'd0: begin
            rd_val[DEPTH_LOG2:0] = cnt_q;
            rd_val[8]            = ovf_q;
            rd_val[9]            = fifo_empty;
            rd_val[10]           = scan_busy;
            rd_val[23:16]        = drop_q;
         end
         2'd1: begin
            if (!fifo_empty) rd_val = {1'b1, 10'd0, mem_q[rd_ptr_q]};
         end
         2'd2: rd_val[1:0] = {irqen_q, en_q};
         default: rd_val[15:0] = snap_state_q;
      endcase
   end

   // Free-running prescaler and millisecond timestamp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         ts_q  <= '0;
      end else if (pre_q == PRE_LAST) begin
         pre_q <= '0;
         ts_q  <= ts_q + 16'd1;
      end else begin
         pre_q <= pre_q + PRE_ONE;
      end
   end

   // Report capture and per-bit scan bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q       <= '0;
         snap_state_q <= '0;
         snap_ts_q    <= '0;
      end else begin
         pend_q <= pend_d;
         if (capture) begin
            snap_state_q <= btn_state;
            snap_ts_q    <= ts_q;
         end
      end
   end

   // Event FIFO storage, pointers and level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= scan_evt;
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_ONE;
            2'b01:   cnt_q <= cnt_q - CNT_ONE;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Overflow tracking; a drop in the clearing cycle is still recorded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else if (stat_clr) begin
         ovf_q  <= drop;
         drop_q <= {7'd0, drop};
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
   end

   // Control register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q    <= 1'b1;
         irqen_q <= 1'b0;
      end else if (wr_acc && (wb_addr == 2'd2)) begin
         en_q    <= wb_wdata[0];
         irqen_q <= wb_wdata[1];
      end
   end

   // Wishbone ack and read data; data is zero outside the ack cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= wb_acc;
         rdata_q <= rd_acc ? rd_val : '0;
      end
   end

   // Registered level interrupt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_q <= 1'b0;
      else        irq_q <= irqen_q & (~fifo_empty | ovf_q);
   end

endmodule

// File: tb/tb_btn_evt_fifo_wb.sv
// Self-checking bench for btn_evt_fifo_wb: register table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_btn_evt_fifo_wb;

   localparam int DL    = 4;
   localparam int TD    = 4;
   localparam int DEPTH = 1 << DL;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] btn_state = '0, btn_change = '0;
   logic        btn_stb = 1'b0;
   logic [1:0]  wb_addr = '0;
   logic [31:0] wb_rdata;
   logic [31:0] wb_wdata = '0;
   logic        wb_we = 1'b0, wb_cyc = 1'b0;
   logic        wb_ack, irq;

   btn_evt_fifo_wb #(.DEPTH_LOG2(DL), .TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_state(btn_state), .btn_change(btn_change), .btn_stb(btn_stb),
      .wb_addr(wb_addr), .wb_rdata(wb_rdata), .wb_wdata(wb_wdata),
      .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   // Reference model: edges since reset, event queue, pending mask.
   int unsigned m_cyc;
   logic [20:0] m_q [$];
   logic [15:0] m_pend, m_snap_state, m_snap_ts;
   logic        m_ovf, m_en, m_irqen, m_ack, m_irq;
   int          m_drop;
   logic [31:0] m_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cyc = 0; m_q.delete(); m_pend = '0; m_snap_state = '0; m_snap_ts = '0;
      m_ovf = 0; m_drop = 0; m_en = 1; m_irqen = 0; m_ack = 0; m_irq = 0; m_rdata = '0;
   endtask

   // One clock: drive inputs, advance model, compare registered outputs.
   task automatic tick(input logic stb, input logic [15:0] st, input logic [15:0] ch,
                       input logic cyc, input logic [1:0] addr, input logic we,
                       input logic [31:0] wd);
      logic        acc, pop, busy, drop, nirq;
      logic [31:0] nrd;
      logic [15:0] npend, ts_now;
      logic [20:0] ev;
      int          i;
      btn_stb = stb; btn_state = st; btn_change = ch;
      wb_cyc = cyc; wb_addr = addr; wb_we = we; wb_wdata = wd;
      ts_now = 16'(m_cyc / TD);
      acc  = cyc && !m_ack;
      busy = (m_pend != 0);
      nrd  = '0; pop = 0; drop = 0;
      if (acc && !we) begin
         case (addr)
            2'd0: nrd = {8'h0, 8'(m_drop), 5'h0, busy, (m_q.size() == 0), m_ovf,
                         3'h0, 5'(m_q.size())};
            2'd1: if (m_q.size() > 0) begin nrd = {1'b1, 10'h0, m_q[0]}; pop = 1; end
            2'd2: nrd = {30'h0, m_irqen, m_en};
            default: nrd = {16'h0, m_snap_state};
         endcase
      end
      nirq  = m_irqen && ((m_q.size() != 0) || m_ovf);
      npend = m_pend;
      if (pop) void'(m_q.pop_front());
      if (busy) begin
         i = 0;
         while (!m_pend[i]) i++;
         ev = {m_snap_state[i], 4'(i), m_snap_ts};
         npend[i] = 1'b0;
         if (m_q.size() < DEPTH) m_q.push_back(ev);
         else drop = 1;
      end
      if (acc && we && addr == 2'd0 && wd[8]) begin m_ovf = 0; m_drop = 0; end
      if (drop) begin m_ovf = 1; if (m_drop < 255) m_drop++; end
      if (stb && m_en) begin npend |= ch; m_snap_state = st; m_snap_ts = ts_now; end
      if (acc && we && addr == 2'd2) begin m_en = wd[0]; m_irqen = wd[1]; end
      m_pend = npend; m_ack = acc; m_rdata = nrd; m_irq = nirq; m_cyc++;
      @(posedge clk); #1;
      check("wb_ack", {31'h0, wb_ack}, {31'h0, m_ack});
      check("wb_rdata", wb_rdata, m_rdata);
      check("irq", {31'h0, irq}, {31'h0, m_irq});
   endtask

   task automatic idle();
      tick(1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 32'h0);
   endtask

   task automatic stb(input logic [15:0] st, input logic [15:0] ch);
      tick(1'b1, st, ch, 1'b0, 2'd0, 1'b0, 32'h0);
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
      tick(1'b0, 16'h0, 16'h0, 1'b1, a, 1'b0, 32'h0);
      d = wb_rdata;
      idle();
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] wd);
      tick(1'b0, 16'h0, 16'h0, 1'b1, a, 1'b1, wd);
      idle();
   endtask

   task automatic do_reset();
      btn_stb = 0; wb_cyc = 0; wb_we = 0;
      rst_n = 1'b0;
      #2;
      check("rst_ack", {31'h0, wb_ack}, 32'h0);
      check("rst_rdata", wb_rdata, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic [1:0]  addr;
      logic        we;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [31:0] d;
      logic [15:0] ch;
      logic [1:0]  a;
      logic [31:0] wd;

      tbl[0]  = '{2'd0, 1'b0, 32'h0,         32'h0000_0200};
      tbl[1]  = '{2'd2, 1'b0, 32'h0,         32'h0000_0001};
      tbl[2]  = '{2'd1, 1'b0, 32'h0,         32'h0000_0000};
      tbl[3]  = '{2'd3, 1'b0, 32'h0,         32'h0000_0000};
      tbl[4]  = '{2'd2, 1'b1, 32'hFFFF_FFF2, 32'h0};
      tbl[5]  = '{2'd2, 1'b0, 32'h0,         32'h0000_0002};
      tbl[6]  = '{2'd2, 1'b1, 32'h0000_0001, 32'h0};
      tbl[7]  = '{2'd2, 1'b0, 32'h0,         32'h0000_0001};
      tbl[8]  = '{2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0};
      tbl[9]  = '{2'd0, 1'b0, 32'h0,         32'h0000_0200};
      tbl[10] = '{2'd3, 1'b1, 32'h0000_1234, 32'h0};
      tbl[11] = '{2'd3, 1'b0, 32'h0,         32'h0000_0000};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Register table after reset.
      for (int k = 0; k < 12; k++) begin
         if (tbl[k].we) wb_write(tbl[k].addr, tbl[k].wd);
         else begin
            wb_read(tbl[k].addr, d);
            check($sformatf("tbl%0d", k), d, tbl[k].exp);
         end
      end

      // Two events captured at ts=5.
      do_reset();
      while (m_cyc != 5 * TD) idle();
      stb(16'h0001, 16'h0011);
      idle(); idle();
      wb_read(2'd1, d); check("ev_ts5_a", d, 32'h8010_0005);
      wb_read(2'd1, d); check("ev_ts5_b", d, 32'h8004_0005);
      wb_read(2'd1, d); check("ev_empty", d, 32'h0);

      // Back-to-back reports merge in index order.
      stb(16'hAAAA, 16'h0003);
      stb(16'h5555, 16'h0004);
      repeat (3) idle();
      for (int k = 0; k < 3; k++) begin
         wb_read(2'd1, d);
         check($sformatf("merge_idx%0d", k), {d[31], 27'h0, d[19:16]}, {1'b1, 27'h0, 4'(k)});
      end
      wb_read(2'd3, d); check("state_last", d, 32'h0000_5555);

      // Overflow, drop counting, saturation and clear.
      stb(16'h0000, 16'hFFFF);
      repeat (20) idle();
      stb(16'h0000, 16'h000F);
      repeat (6) idle();
      wb_read(2'd0, d); check("ovf_status", d, 32'h0004_0110);
      wb_write(2'd0, 32'h0000_0100);
      wb_read(2'd0, d); check("ovf_clear", d, 32'h0000_0010);
      for (int k = 0; k < 16; k++) begin
         stb(16'h0000, 16'hFFFF);
         repeat (17) idle();
      end
      wb_read(2'd0, d); check("drop_sat", d, 32'h00FF_0110);
      wb_write(2'd0, 32'h0000_0100);
      wb_read(2'd0, d); check("sat_clear", d, 32'h0000_0010);
      for (int k = 0; k < 16; k++) wb_read(2'd1, d);
      wb_read(2'd0, d); check("drained", d, 32'h0000_0200);

      // Interrupt gating and enable.
      stb(16'h0001, 16'h0001);
      idle(); idle();
      check("irq_masked", {31'h0, irq}, 32'h0);
      tick(1'b0, 16'h0, 16'h0, 1'b1, 2'd2, 1'b1, 32'h3);
      check("irq_wait", {31'h0, irq}, 32'h0);
      idle();
      check("irq_on", {31'h0, irq}, 32'h1);
      wb_read(2'd1, d);
      check("irq_off", {31'h0, irq}, 32'h0);
      wb_write(2'd2, 32'h2);
      stb(16'hFFFF, 16'h000F);
      repeat (3) idle();
      wb_read(2'd0, d); check("disabled", d, 32'h0000_0200);
      check("irq_dis", {31'h0, irq}, 32'h0);
      wb_write(2'd2, 32'h1);

      // Timestamp after 40 cycles at TICK_DIV=4.
      do_reset();
      repeat (40) idle();
      stb(16'h0001, 16'h0001);
      idle();
      wb_read(2'd1, d); check("ts10", d, 32'h8010_000A);

      // Reset in the middle of a scan and an access.
      stb(16'hFFFF, 16'hFFFF);
      tick(1'b0, 16'h0, 16'h0, 1'b1, 2'd0, 1'b0, 32'h0);
      do_reset();
      wb_read(2'd0, d); check("post_rst", d, 32'h0000_0200);

      // Randomized run against the model.
      wb_write(2'd2, 32'h3);
      for (int n = 0; n < 3000; n++) begin
         ch = 16'($urandom) & 16'($urandom) & 16'($urandom);
         a  = ($urandom_range(0, 9) < 6) ? 2'd1 : 2'($urandom);
         wd = $urandom;
         if (a == 2'd2) wd[0] = ($urandom_range(0, 9) != 0);
         tick(($urandom_range(0, (n < 1500) ? 7 : 29) == 0), 16'($urandom), ch,
              $urandom_range(0, 1) == 1, a, $urandom_range(0, 4) == 0, wd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
